// File: rtl/rot_pkg.sv
// Shared types and helpers for the sequential left rotator.
package rot_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic [WIDTH_DEF-1:0] rotl1(
    input logic [WIDTH_DEF-1:0] x
  );
    return {x[WIDTH_DEF-2:0], x[WIDTH_DEF-1]};
  endfunction

endpackage

// File: rtl/rot_step_left.sv
// One-bit combinational left rotate.
module rot_step_left #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  assign y = {x[WIDTH-2:0], x[WIDTH-1]};

endmodule

// File: rtl/rot_left_seq.sv
// Multi-cycle left rotator: one bit per clock,
// valid/ready on both sides, no overlap.
module rot_left_seq
  import rot_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  localparam int AMTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMTW-1:0]  in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_nxt;
  logic [WIDTH-1:0] step;
  logic [AMTW-1:0]  count;
  logic [AMTW-1:0]  count_nxt;

  rot_step_left #(
    .WIDTH (WIDTH)
  ) u_step (
    .x (data_reg),
    .y (step)
  );

  always_comb begin
    state_nxt = state;
    data_nxt  = data_reg;
    count_nxt = count;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          data_nxt  = in_data;
          count_nxt = in_amt;
          state_nxt = (in_amt == '0) ? HOLD : SHIFT;
        end
      end
      SHIFT: begin
        data_nxt  = step;
        count_nxt = count - 1'b1;
        if (count == AMTW'(1))
          state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_reg <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      data_reg <= data_nxt;
      count    <= count_nxt;
    end
  end

  // All handshake outputs decode registered state only.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign out_data  = data_reg;

endmodule

// File: doc/rot_left_seq.md
Name: rot_left_seq

Overview:
- Multi-cycle left rotator; the inverse of the combinational right-rotate barrel stage.
- Takes an operand and a rotate amount through a valid/ready input handshake. Rotates the operand left by one bit per clock, then holds the result on a valid/ready output handshake.
- Sits on the receive side of any path that applies a right rotation, and restores the original word.
- Selected over a combinational barrel for area. Throughput is secondary.

Parameters:
- WIDTH, 8, operand width in bits. Must be a power of 2 and at least 2.
- AMTW, $clog2(WIDTH) = 3, width of the rotate-amount field. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand and amount are valid.
- in_ready  output  1  block can accept a new operand.
- in_data  input  WIDTH  operand to rotate.
- in_amt  input  AMTW  left-rotate amount, 0..WIDTH-1.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  rotated result.
- busy  output  1  high in SHIFT and HOLD.

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high, sampled on the rising edge.
- Reset values: state=IDLE, out_valid=0, out_data=0, busy=0, count=0. After reset, in_ready=1.
- in_ready is a registered-state decode: 1 only in IDLE, with no combinational path from in_valid or out_ready.
- IDLE:
  - An accept happens on an edge where in_valid && in_ready.
  - On accept: data_reg<=in_data, count<=in_amt.
  - If in_amt==0, go to HOLD; otherwise go to SHIFT.
- SHIFT:
  - Each edge: data_reg<={data_reg[WIDTH-2:0],data_reg[WIDTH-1]} and count<=count-1.
  - The edge on which count==1 performs the last shift and moves to HOLD.
- HOLD:
  - out_valid=1 and out_data=data_reg.
  - On an edge with out_ready=1, go to IDLE and clear out_valid.
  - out_data and out_valid stay stable while out_ready=0, indefinitely.
- Latency: out_valid first rises in the cycle following edge amt+1 after the accept edge. That is 1 cycle for amt=0 and 8 cycles for amt=7 at WIDTH=8.
- No overlap:
  - in_ready=0 throughout SHIFT and HOLD. in_valid is ignored there, and in_data/in_amt are don't-care.
  - At least one IDLE cycle separates results.
  - Maximum throughput is one result per amt+2 cycles.
- Simultaneous events:
  - The out_ready handshake in HOLD and a new in_valid in the same cycle: only the output handshake completes. The input is accepted in the following IDLE cycle, provided in_valid is still held.
- rst mid-operation, in SHIFT or HOLD: the pending result is discarded. Next cycle: IDLE, out_valid=0, in_ready=1, no output produced.
- Arithmetic:
  - count is AMTW bits and never underflows; SHIFT is never entered with count==0.
  - The amount is unsigned, and the full 0..WIDTH-1 range is legal.
- Invariant: for any x and c, applying this block to (right-rotate of x by c, c) returns x.

Decomposition:
- Package rot_pkg holds:
  - the state enum {IDLE, SHIFT, HOLD} (2-bit encoding);
  - the default WIDTH constant;
  - a function for single-bit left rotate, shared with the verification golden model.
- One natural sub-module, rot_step_left: a combinational one-bit left rotate, WIDTH-parameterised. It is instantiated once, feeding data_reg in SHIFT.
- The FSM, counter and handshake logic stay in rot_left_seq.

Test Plan:
- Reset → in the cycle after rst drops: in_ready=1, out_valid=0, out_data=8'h00, busy=0.
- in_data=8'b1000_0001, in_amt=1, out_ready=1 → out_valid high 2 cycles after accept with out_data=8'b0000_0011; busy high for 2 cycles.
- in_data=8'h3C, in_amt=0 → out_valid high 1 cycle after accept with out_data=8'h3C; SHIFT is never visited.
- in_data=8'h01, in_amt=7 → out_valid rises 8 cycles after accept with out_data=8'h80. in_valid pulsed with 8'hFF during SHIFT is not accepted (in_ready=0).
- Backpressure: in_data=8'hA5, amt=3 → out_data=8'h2D. Hold out_ready=0 for 5 cycles → out_data stays 8'h2D and out_valid stays 1; release → one handshake, then IDLE.
- Reset and round trip:
  - Assert rst at shift cycle 2 of in_data=8'hF0, amt=5 → no out_valid, IDLE next cycle.
  - Then 1000 random (x,c) pairs fed with the right-rotated x and c, under random out_ready → each out_data equals x.
